// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_loader_pkg;

  localparam int IMEM_SIZE = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASM,
    S_SETPC,
    S_WRITE,
    S_REL,
    S_RUN
  } state_t;

  // One extra bit so an address equal to the memory depth is representable.
  function automatic int addr_width(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, load control and fetch-stage signals of the loader.
interface imem_loader_if;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] core_new_pc;
  logic        if_rst;
  logic        if_we;
  logic [31:0] if_new_pc;
  logic [31:0] if_wins;
  logic        busy;
  logic        run;
  logic        err;

  modport master (
    output start, len, in_valid, in_data, core_new_pc,
    input  in_ready, if_rst, if_we, if_new_pc, if_wins, busy, run, err
  );

  modport slave (
    input  start, len, in_valid, in_data, core_new_pc,
    output in_ready, if_rst, if_we, if_new_pc, if_wins, busy, run, err
  );
endinterface

// File: rtl/imem_word_asm.sv
// Packs accepted bytes little-endian into a 32-bit word; word_valid marks the 4th byte.
module imem_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] cnt;

  assign word_valid = take && (cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (take) begin
      word[{cnt, 3'b000} +: 8] <= data;
      cnt                      <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a host byte stream into the fetch stage's instruction memory, then releases the core.
//   state | meaning
//   IDLE  | core held in reset, waiting for start
//   ASM   | collecting four bytes of the current word
//   SETPC | fetch PC pointed at the target word
//   WRITE | word written at the held PC
//   REL   | one-cycle fetch reset so the core starts at PC 0
//   RUN   | core running from its own next-PC
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_SIZE = imem_loader_pkg::IMEM_SIZE
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  localparam int AW = addr_width(IMEM_SIZE);
  localparam int CW = (AW > 8) ? AW : 8;

  state_t        state, state_nx;
  logic [AW-1:0] addr;
  logic [7:0]    len_q;
  logic          err_q;
  logic          start_can, start_zero, start_big, start_ok;
  logic          take, word_valid;
  logic [31:0]   word;
  logic [CW-1:0] addr_inc;
  logic [31:0]   pc_word;

  assign start_can  = bus.start && (state == S_IDLE || state == S_RUN);
  assign start_big  = start_can && ({24'd0, bus.len} > 32'(IMEM_SIZE));
  assign start_zero = start_can && (bus.len == 8'd0);
  assign start_ok   = start_can && !start_big && !start_zero;
  assign take       = bus.in_valid && (state == S_ASM);
  assign addr_inc   = CW'(addr) + CW'(1);
  assign pc_word    = 32'({addr, 2'b00});

  imem_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .take       (take),
    .data       (bus.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_RUN: begin
        if (start_zero)    state_nx = S_REL;
        else if (start_ok) state_nx = S_ASM;
      end
      S_ASM:   if (word_valid) state_nx = S_SETPC;
      S_SETPC: state_nx = S_WRITE;
      S_WRITE: state_nx = (addr_inc == CW'(len_q)) ? S_REL : S_ASM;
      S_REL:   state_nx = S_RUN;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (start_big)                    err_q <= 1'b1;
      else if (start_ok || start_zero)  err_q <= 1'b0;
      if (start_ok) begin
        len_q <= bus.len;
        addr  <= '0;
      end else if (state == S_WRITE) begin
        addr <= addr + 1'b1;
      end
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.if_rst    = 1'b0;
    bus.if_we     = 1'b0;
    bus.if_new_pc = 32'd0;
    bus.if_wins   = 32'd0;
    bus.busy      = 1'b0;
    bus.run       = 1'b0;
    bus.err       = err_q;
    case (state)
      S_IDLE: bus.if_rst = 1'b1;
      S_ASM: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      S_SETPC: begin
        bus.if_new_pc = pc_word;
        bus.busy      = 1'b1;
      end
      // PC stays on the target word so the write lands at addr.
      S_WRITE: begin
        bus.if_we     = 1'b1;
        bus.if_wins   = word;
        bus.if_new_pc = pc_word;
        bus.busy      = 1'b1;
      end
      S_REL: begin
        bus.if_rst = 1'b1;
        bus.busy   = 1'b1;
      end
      S_RUN: begin
        bus.if_new_pc = bus.core_new_pc;
        bus.run       = 1'b1;
      end
      default: bus.if_rst = 1'b1;
    endcase
  end

endmodule
